result_writer: RTL and testbench
================================

RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 20, SRAM word address width; DATA_WIDTH, 16, SRAM data width; RTF_WIDTH, 24, result word width (fixed at 24); CNT_WIDTH, 16, vector count width.
REQ-002 SHALL have one clock; reset is synchronous and active-high; ports: clock  in  1  block clock; reset  in  1  synchronous active-high reset.
REQ-003 enable  in  1  start request; done  out  1  run complete, held.
REQ-004 base_addr  in  ADDR_WIDTH  first record address; vec_count  in  CNT_WIDTH  results to process; both sampled when a run starts.
REQ-005 rfifo_dataq  in  RTF_WIDTH  result data; rfifo_rdempty  in  1  FIFO empty; rfifo_rdreq  out  1  pop strobe (non-show-ahead FIFO).
REQ-006 exp_data  in  RTF_WIDTH  expected value; exp_mask  in  RTF_WIDTH  1 = bit compared; exp_valid  in  1; exp_ready  out  1.
REQ-007 address  out  ADDR_WIDTH; byteenable  out  DATA_WIDTH/8; write  out  1; writedata  out  DATA_WIDTH; waitrequest  in  1.
REQ-008 mismatch_count  out  CNT_WIDTH  failing vectors in current/last run.

Function
REQ-009 SHALL implement states IDLE, POP, LATCH, WAIT_EXP, WR_LO, WR_HI, DONE.
REQ-010 IDLE: on enable=1, latch base_addr/vec_count, clear mismatch_count; go DONE if vec_count=0, else POP.
REQ-011 POP: assert rfifo_rdreq for exactly one cycle only when rfifo_rdempty=0, then LATCH; while empty, wait in POP with rfifo_rdreq=0.
REQ-012 LATCH: capture rfifo_dataq (valid the cycle after rdreq), go WAIT_EXP.
REQ-013 WAIT_EXP: exp_ready=1 for a single cycle when exp_valid=1; capture exp_data/exp_mask on that transfer, go WR_LO; exp_ready=0 in every other state.
REQ-014 fail = |((result ^ exp_data) & exp_mask); on fail, mismatch_count increments, saturating at all-ones.
REQ-015 WR_LO: write=1, address=current address, writedata=result[15:0], byteenable all ones.
REQ-016 WR_HI: write=1, address=current address+1, writedata={fail, 7'b0, result[23:16]}.
REQ-017 While waitrequest=1, write, address, writedata, byteenable SHALL stay stable; a word completes on the first cycle with write=1 and waitrequest=0.
REQ-018 After WR_HI completes: address advances by 2 (modulo 2^ADDR_WIDTH, wrap silently); remaining count decrements; go POP if nonzero, else DONE.
REQ-019 DONE: done=1; return to IDLE on the cycle enable=0; mismatch_count held until next start.
REQ-020 enable changes while not in IDLE or DONE SHALL be ignored.
REQ-021 Best-case throughput: one vector per 5 cycles (POP, LATCH, WAIT_EXP, WR_LO, WR_HI) with zero waitrequest and exp_valid held high.

Reset
REQ-022 reset=1 SHALL force state IDLE and, from the next edge, done, rfifo_rdreq, exp_ready, write = 0, address, writedata, byteenable, mismatch_count = 0, including mid-write (bus write abandoned).
REQ-023 reset SHALL take priority over all other inputs on the same edge.

Structure
REQ-024 State encoding, record layout constants (LO offset 0, HI offset 1, FAIL_BIT 15, RECORD_WORDS 2) SHALL live in shared package tester_pkg.
REQ-025 Mask-compare plus saturating mismatch counter SHALL be a sub-module result_cmp; FSM and bus logic in result_writer.

Verification
REQ-026 base_addr=0x00100, vec_count=1, result 0x123456, exp 0x123456, mask 0xFFFFFF -> writes 0x3456@0x00100, 0x0012@0x00101, mismatch_count=0, done=1.
REQ-027 result 0xABCDEF, exp 0xABCDE0, mask 0xFFFFF0 -> pass; mask 0xFFFFFF -> HI word 0x80AB, mismatch_count=1.
REQ-028 waitrequest high 3 cycles on each write, rfifo_rdempty high 4 cycles before second vector -> outputs stable during stall, no rdreq while empty, 2 records correct.
REQ-029 base_addr=0xFFFFE, vec_count=2 -> second record at 0x00000/0x00001; vec_count=0 -> done next cycle, no rdreq, no write.
REQ-030 reset asserted during WR_HI stall -> next cycle write=0, state IDLE, mismatch_count=0; new run completes normally.

Source files
------------

// File: rtl/tester_pkg.sv
// Shared FSM encoding and result-record layout for the result writer.
package tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LATCH,
    ST_WAIT_EXP,
    ST_WR_LO,
    ST_WR_HI,
    ST_DONE
  } state_e;

  // Each result occupies two consecutive SRAM words; the pass/fail flag rides in the HI word MSB.
  localparam int LO_OFFSET    = 0;
  localparam int HI_OFFSET    = 1;
  localparam int FAIL_BIT     = 15;
  localparam int RECORD_WORDS = 2;

endpackage

// File: rtl/result_cmp.sv
// Masked compare of a result against its expected value plus a saturating fail counter.
module result_cmp
  import tester_pkg::*;
#(
  parameter int RTF_WIDTH = 24,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 update,
  input  logic [RTF_WIDTH-1:0] result,
  input  logic [RTF_WIDTH-1:0] exp_data,
  input  logic [RTF_WIDTH-1:0] exp_mask,
  output logic                 fail,
  output logic [CNT_WIDTH-1:0] mismatch_count
);

  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

  assign fail           = |((result ^ exp_data) & exp_mask);
  assign mismatch_count = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (update && fail && (cnt_q != '1))
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/result_writer.sv
// Pops results from a FIFO, checks them against expected values and writes
// two-word records (LO data, HI data + fail flag) to SRAM.
module result_writer
  import tester_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int RTF_WIDTH  = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    done,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [CNT_WIDTH-1:0]    vec_count,
  input  logic [RTF_WIDTH-1:0]    rfifo_dataq,
  input  logic                    rfifo_rdempty,
  output logic                    rfifo_rdreq,
  input  logic [RTF_WIDTH-1:0]    exp_data,
  input  logic [RTF_WIDTH-1:0]    exp_mask,
  input  logic                    exp_valid,
  output logic                    exp_ready,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic [DATA_WIDTH/8-1:0] byteenable,
  output logic                    write,
  output logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    waitrequest,
  output logic [CNT_WIDTH-1:0]    mismatch_count
);

  state_e                state_d, state_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [CNT_WIDTH-1:0]  remain_d, remain_q;
  logic [RTF_WIDTH-1:0]  result_d, result_q;
  logic [RTF_WIDTH-1:0]  exp_data_d, exp_data_q;
  logic [RTF_WIDTH-1:0]  exp_mask_d, exp_mask_q;
  logic                  cnt_clear, cnt_update, fail;

  result_cmp #(
    .RTF_WIDTH (RTF_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cmp (
    .clk            (clock),
    .reset          (reset),
    .clear          (cnt_clear),
    .update         (cnt_update),
    .result         (result_q),
    .exp_data       (exp_data_q),
    .exp_mask       (exp_mask_q),
    .fail           (fail),
    .mismatch_count (mismatch_count)
  );

  // Bus outputs are pure functions of the registered state, so they hold through waitrequest.
  always_comb begin
    rfifo_rdreq = (state_q == ST_POP) && !rfifo_rdempty;
    exp_ready   = (state_q == ST_WAIT_EXP) && exp_valid;
    done        = (state_q == ST_DONE);
    write       = 1'b0;
    address     = '0;
    writedata   = '0;
    byteenable  = '0;
    if (state_q == ST_WR_LO) begin
      write      = 1'b1;
      address    = addr_q + ADDR_WIDTH'(LO_OFFSET);
      writedata  = result_q[DATA_WIDTH-1:0];
      byteenable = '1;
    end else if (state_q == ST_WR_HI) begin
      write               = 1'b1;
      address             = addr_q + ADDR_WIDTH'(HI_OFFSET);
      writedata[7:0]      = result_q[RTF_WIDTH-1:16];
      writedata[FAIL_BIT] = fail;
      byteenable          = '1;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    result_d   = result_q;
    exp_data_d = exp_data_q;
    exp_mask_d = exp_mask_q;
    cnt_clear  = 1'b0;
    cnt_update = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          addr_d    = base_addr;
          remain_d  = vec_count;
          cnt_clear = 1'b1;
          state_d   = (vec_count == '0) ? ST_DONE : ST_POP;
        end
      end
      ST_POP: begin
        if (!rfifo_rdempty) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        result_d = rfifo_dataq;
        state_d  = ST_WAIT_EXP;
      end
      ST_WAIT_EXP: begin
        if (exp_valid) begin
          exp_data_d = exp_data;
          exp_mask_d = exp_mask;
          state_d    = ST_WR_LO;
        end
      end
      ST_WR_LO: begin
        // Count the vector once, when its first word is accepted.
        if (!waitrequest) begin
          cnt_update = 1'b1;
          state_d    = ST_WR_HI;
        end
      end
      ST_WR_HI: begin
        if (!waitrequest) begin
          addr_d   = addr_q + ADDR_WIDTH'(RECORD_WORDS);
          remain_d = remain_q - CNT_WIDTH'(1);
          state_d  = (remain_q == CNT_WIDTH'(1)) ? ST_DONE : ST_POP;
        end
      end
      ST_DONE: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      result_q   <= '0;
      exp_data_q <= '0;
      exp_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      result_q   <= result_d;
      exp_data_q <= exp_data_d;
      exp_mask_q <= exp_mask_d;
    end
  end

endmodule

// File: tb/tb_result_writer.sv
// Scoreboard bench for result_writer: FIFO/expected/SRAM models plus a write monitor.
module tb_result_writer;
  localparam int AW = 20, DW = 16, RW = 24, CW = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          enable = 1'b0, done;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] vec_count = '0;
  logic [RW-1:0] rfifo_dataq = '0;
  logic          rfifo_rdempty = 1'b1, rfifo_rdreq;
  logic [RW-1:0] exp_data = '0, exp_mask = '0;
  logic          exp_valid = 1'b0, exp_ready;
  logic [AW-1:0] address;
  logic [DW/8-1:0] byteenable;
  logic          write;
  logic [DW-1:0] writedata;
  logic          waitrequest = 1'b0;
  logic [CW-1:0] mismatch_count;

  result_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RTF_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .done(done),
    .base_addr(base_addr), .vec_count(vec_count),
    .rfifo_dataq(rfifo_dataq), .rfifo_rdempty(rfifo_rdempty), .rfifo_rdreq(rfifo_rdreq),
    .exp_data(exp_data), .exp_mask(exp_mask), .exp_valid(exp_valid), .exp_ready(exp_ready),
    .address(address), .byteenable(byteenable), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .mismatch_count(mismatch_count)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [RW-1:0] data; int delay; } fe_t;
  typedef struct { logic [RW-1:0] data; logic [RW-1:0] mask; } ee_t;

  wr_t sb[$];
  fe_t fq[$];
  ee_t eq[$];

  int n_cmp = 0, n_fail = 0;
  int wait_n = 0, wcnt = 0, hold = 0, wr_done = 0;
  logic rd_fire = 1'b0, exp_fire = 1'b0, wr_fire = 1'b0;
  logic stalled = 1'b0;
  logic [AW+DW+DW/8-1:0] st_snap = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge; records what will be accepted on the next rising edge.
  always @(negedge clock) begin
    rd_fire  = rfifo_rdreq;
    exp_fire = exp_ready;
    wr_fire  = write && !waitrequest;
    if (rfifo_rdreq) chk("rdreq_while_empty", 64'(rfifo_rdempty), 64'd0);
    if (write && waitrequest) begin
      if (stalled) chk("stall_stable", 64'({address, writedata, byteenable}), 64'(st_snap));
      stalled = 1'b1;
      st_snap = {address, writedata, byteenable};
    end else begin
      stalled = 1'b0;
    end
    if (wr_fire) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", address, writedata);
      end else begin
        wr_t w;
        w = sb.pop_front();
        chk("wr_addr", 64'(address), 64'(w.addr));
        chk("wr_data", 64'(writedata), 64'(w.data));
        chk("wr_be", 64'(byteenable), 64'(2'b11));
      end
    end
  end

  // Environment models: result FIFO, expected-value source, SRAM waitrequest.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      hold = 0; wcnt = 0; wr_done = 0;
    end
    if (hold > 0) hold--;
    if (rd_fire && fq.size() > 0) begin
      fe_t f;
      f = fq.pop_front();
      rfifo_dataq = f.data;
    end
    if (exp_fire && eq.size() > 0) begin
      ee_t e;
      e = eq.pop_front();
    end
    if (wr_fire && !reset) begin
      wr_done++;
      if ((wr_done % 2) == 0 && fq.size() > 0) hold = fq[0].delay;
    end
    rd_fire = 1'b0; exp_fire = 1'b0; wr_fire = 1'b0;
    if (write && wcnt < wait_n) begin
      waitrequest = 1'b1;
      wcnt++;
    end else begin
      waitrequest = 1'b0;
      wcnt = 0;
    end
    exp_valid = (eq.size() > 0);
    exp_data  = exp_valid ? eq[0].data : '0;
    exp_mask  = exp_valid ? eq[0].mask : '0;
    rfifo_rdempty = (fq.size() == 0) || (hold > 0) || write;
  end

  task automatic add_vec(input logic [AW-1:0] a, input logic [RW-1:0] res, input logic [RW-1:0] ed,
                         input logic [RW-1:0] em, input int dly,
                         input logic [DW-1:0] lo, input logic [DW-1:0] hi);
    fe_t f;
    ee_t e;
    wr_t w;
    f.data = res; f.delay = dly; fq.push_back(f);
    e.data = ed;  e.mask = em;   eq.push_back(e);
    w.addr = a;            w.data = lo; sb.push_back(w);
    w.addr = a + AW'(1);   w.data = hi; sb.push_back(w);
  endtask

  task automatic do_run(input string name, input logic [AW-1:0] b, input logic [CW-1:0] n,
                        input logic [CW-1:0] exp_mm, input bit drop_en);
    int t;
    @(negedge clock);
    base_addr = b; vec_count = n; enable = 1'b1;
    @(negedge clock);
    if (drop_en) enable = 1'b0;  // must be ignored mid-run
    t = 0;
    while (!done && t < 400) begin
      @(negedge clock);
      t++;
    end
    chk({name, "_done"}, 64'(done), 64'd1);
    enable = 1'b0;
    @(negedge clock);
    chk({name, "_mm"}, 64'(mismatch_count), 64'(exp_mm));
    chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    @(negedge clock);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clock);
    chk("rst_outputs", 64'({done, rfifo_rdreq, exp_ready, write, address, writedata, byteenable}), 64'd0);
    chk("rst_mm", 64'(mismatch_count), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Exact match.
    add_vec(20'h00100, 24'h123456, 24'h123456, 24'hFFFFFF, 0, 16'h3456, 16'h0012);
    do_run("t1", 20'h00100, 16'd1, 16'd0, 1'b0);

    // Masked pass then full-mask fail; enable dropped mid-run.
    add_vec(20'h00200, 24'hABCDEF, 24'hABCDE0, 24'hFFFFF0, 0, 16'hCDEF, 16'h00AB);
    add_vec(20'h00202, 24'hABCDEF, 24'hABCDE0, 24'hFFFFFF, 0, 16'hCDEF, 16'h80AB);
    do_run("t2", 20'h00200, 16'd2, 16'd1, 1'b1);

    // Bus stalls of 3 cycles per word and FIFO empty for 4 cycles before vector 2.
    wait_n = 3;
    add_vec(20'h00300, 24'h000001, 24'h000001, 24'hFFFFFF, 0, 16'h0001, 16'h0000);
    add_vec(20'h00302, 24'hFF00FF, 24'h0000FF, 24'hFF0000, 4, 16'h00FF, 16'h80FF);
    do_run("t3", 20'h00300, 16'd2, 16'd1, 1'b0);
    wait_n = 0;

    // Zero-length run: done on the next cycle, counter cleared.
    @(negedge clock);
    base_addr = 20'h00800; vec_count = '0; enable = 1'b1;
    @(negedge clock);
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_mm", 64'(mismatch_count), 64'd0);
    chk("t5_nowrite", 64'(write), 64'd0);
    enable = 1'b0;
    repeat (2) @(negedge clock);

    // Address wrap at the top of the space.
    add_vec(20'hFFFFE, 24'h000111, 24'h000111, 24'hFFFFFF, 0, 16'h0111, 16'h0000);
    add_vec(20'h00000, 24'h222222, 24'h222222, 24'h000000, 0, 16'h2222, 16'h0022);
    do_run("t4", 20'hFFFFE, 16'd2, 16'd0, 1'b0);

    // Reset while the HI word is stalled.
    wait_n = 3;
    add_vec(20'h00400, 24'h000000, 24'h000001, 24'h000001, 0, 16'h0000, 16'h8000);
    @(negedge clock);
    base_addr = 20'h00400; vec_count = 16'd1; enable = 1'b1;
    t = 0;
    while (!(write && waitrequest && address == 20'h00401) && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("t6_hi_stall_seen", 64'(address), 64'h00401);
    chk("t6_mm_before", 64'(mismatch_count), 64'd1);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clock);
    chk("t6_rst_write", 64'(write), 64'd0);
    chk("t6_rst_addr", 64'(address), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_mm", 64'(mismatch_count), 64'd0);
    sb.delete();
    wait_n = 0;
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Normal run after the abandoned one.
    add_vec(20'h00500, 24'h00FACE, 24'h00FACF, 24'h0000FF, 0, 16'hFACE, 16'h8000);
    do_run("t7", 20'h00500, 16'd1, 16'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
